usb_sniffer_axi_burst: RTL and testbench

USB_SNIFFER_AXI_BURST -- requirements
Module: usb_sniffer_axi_burst

---
 rtl/usb_sniffer_axi_burst_pkg.sv | 18 +
 rtl/usb_sniffer_burst_fifo.sv | 62 ++++++
 rtl/usb_sniffer_axi_burst.sv | 195 +++++++++++++++++++
 tb/tb_usb_sniffer_axi_burst.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_sniffer_axi_burst_pkg.sv
// rtl/usb_sniffer_axi_burst_pkg.sv - shared types and constants for the inport-to-AXI4 burst bridge
package usb_sniffer_axi_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_t;

  // Command FIFO entry layout: {rd, len[7:0], addr[31:0]}
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_LEN_LSB  = 32;
  localparam int CMD_RD_BIT   = 40;
  localparam int CMD_W        = 41;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/usb_sniffer_burst_fifo.sv
// rtl/usb_sniffer_burst_fifo.sv - power-of-two FIFO with registered occupancy count
module usb_sniffer_burst_fifo
  import usb_sniffer_axi_burst_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             accept_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_out_o
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign accept_o   = (count_q != FULL_CNT);
  assign valid_o    = (count_q != '0);
  assign data_out_o = mem[rd_ptr_q];

  // A push while full is allowed to land in the slot being popped this cycle.
  assign do_push = push_i & (accept_o | pop_i);
  assign do_pop  = pop_i & valid_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= data_in_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/usb_sniffer_axi_burst.sv
// rtl/usb_sniffer_axi_burst.sv - inport burst requests to AXI4 master with queued commands and write beats
module usb_sniffer_axi_burst
  import usb_sniffer_axi_burst_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int AXI_ID          = 0,
  parameter int CMD_DEPTH       = 8,
  parameter int WDATA_DEPTH     = 16,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W/8-1:0] inport_wr_i,
  input  logic                inport_rd_i,
  input  logic [7:0]          inport_len_i,
  input  logic [31:0]         inport_addr_i,
  input  logic [DATA_W-1:0]   inport_write_data_i,
  output logic                inport_accept_o,
  output logic                inport_ack_o,
  output logic                inport_error_o,
  output logic                inport_last_o,
  output logic [DATA_W-1:0]   inport_read_data_o,
  output logic                awvalid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awid,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  input  logic                awready,
  output logic                wvalid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic                arvalid,
  output logic [31:0]         araddr,
  output logic [3:0]          arid,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  output logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WF_W   = 1 + STRB_W + DATA_W;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BAL_W  = OUT_W + 1;
  localparam logic [31:0] ADDR_MASK = ~(32'(STRB_W) - 32'd1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  state_t            state_q, state_d;
  logic [7:0]        beats_q, beats_d;
  logic              offered, is_write, xfer;
  logic              cmd_push, cmd_pop, cmd_accept, cmd_valid;
  logic [CMD_W-1:0]  cmd_in, cmd_head;
  logic              wf_push, wf_pop, wf_accept, wf_valid, wf_last;
  logic [WF_W-1:0]   wf_in, wf_head;
  logic [OUT_W-1:0]  out_q;
  logic [BAL_W-1:0]  bal_q;
  logic              head_rd, w_allow, aw_hs, ar_hs, w_hs, b_done, r_done;

  assign offered  = inport_rd_i | (|inport_wr_i);
  assign is_write = |inport_wr_i;
  assign cmd_in   = {~is_write, inport_len_i, inport_addr_i};
  assign wf_in    = {wf_last, inport_wr_i, inport_write_data_i};

  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    cmd_push = 1'b0;
    wf_push  = 1'b0;
    wf_last  = 1'b0;
    if (state_q == IDLE) begin
      inport_accept_o = cmd_accept & wf_accept & (out_q < OUT_MAX);
    end else begin
      inport_accept_o = wf_accept;
    end
    xfer = offered & inport_accept_o;
    if (xfer) begin
      if (state_q == IDLE) begin
        cmd_push = 1'b1;
        if (is_write) begin
          wf_push = 1'b1;
          wf_last = (inport_len_i == 8'd0);
          if (inport_len_i != 8'd0) begin
            state_d = WDATA;
            beats_d = inport_len_i;
          end
        end
      end else begin
        wf_push = 1'b1;
        wf_last = (beats_q == 8'd1);
        beats_d = beats_q - 8'd1;
        if (beats_q == 8'd1) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
    end
  end

  usb_sniffer_burst_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH),
    .ADDR_W($clog2(CMD_DEPTH))
  ) u_cmd_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (cmd_push),
    .data_in_i (cmd_in),
    .accept_o  (cmd_accept),
    .pop_i     (cmd_pop),
    .valid_o   (cmd_valid),
    .data_out_o(cmd_head)
  );

  usb_sniffer_burst_fifo #(
    .WIDTH (WF_W),
    .DEPTH (WDATA_DEPTH),
    .ADDR_W($clog2(WDATA_DEPTH))
  ) u_wdata_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (wf_push),
    .data_in_i (wf_in),
    .accept_o  (wf_accept),
    .pop_i     (wf_pop),
    .valid_o   (wf_valid),
    .data_out_o(wf_head)
  );

  assign head_rd = cmd_head[CMD_RD_BIT];
  assign arvalid = cmd_valid & head_rd;
  assign awvalid = cmd_valid & ~head_rd;
  assign awaddr  = cmd_head[CMD_ADDR_LSB +: 32] & ADDR_MASK;
  assign araddr  = cmd_head[CMD_ADDR_LSB +: 32] & ADDR_MASK;
  assign awlen   = cmd_head[CMD_LEN_LSB +: 8];
  assign arlen   = cmd_head[CMD_LEN_LSB +: 8];
  assign awid    = 4'(AXI_ID);
  assign arid    = 4'(AXI_ID);
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;

  assign aw_hs   = awvalid & awready;
  assign ar_hs   = arvalid & arready;
  assign cmd_pop = aw_hs | ar_hs;

  // bal_q = AW bursts accepted minus W bursts finished. It dips to -1 when the
  // presented write finished its data before its AW was taken, which blocks W
  // until that AW goes so the next burst's beats cannot overtake it.
  assign w_allow = (~bal_q[BAL_W-1] & (bal_q != '0)) | ((bal_q == '0) & awvalid);
  assign wvalid  = wf_valid & w_allow;
  assign wdata   = wf_head[DATA_W-1:0];
  assign wstrb   = wf_head[DATA_W +: STRB_W];
  assign wlast   = wf_head[WF_W-1];
  assign w_hs    = wvalid & wready;
  assign wf_pop  = w_hs;

  assign bready = 1'b1;
  assign rready = 1'b1;
  assign b_done = bvalid & bready;
  assign r_done = rvalid & rready & rlast;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      bal_q <= '0;
    end else begin
      out_q <= out_q + OUT_W'(cmd_push) - OUT_W'(b_done) - OUT_W'(r_done);
      bal_q <= bal_q + BAL_W'(aw_hs) - BAL_W'(w_hs & wlast);
    end
  end

  // B wins the shared status path when both responses land together.
  assign inport_ack_o       = bvalid | rvalid;
  assign inport_error_o     = bvalid ? (bresp != AXI_RESP_OKAY) : (rresp != AXI_RESP_OKAY);
  assign inport_read_data_o = rdata;
  assign inport_last_o      = bvalid | (rvalid & rlast);

endmodule

// File: tb/tb_usb_sniffer_axi_burst.sv
// tb/tb_usb_sniffer_axi_burst.sv - directed and randomized bench with AXI slave model and scoreboard
module tb_usb_sniffer_axi_burst;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  inport_wr_i;
  logic        inport_rd_i;
  logic [7:0]  inport_len_i;
  logic [31:0] inport_addr_i;
  logic [31:0] inport_write_data_i;
  logic        inport_accept_o, inport_ack_o, inport_error_o, inport_last_o;
  logic [31:0] inport_read_data_o;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;

  always #5 clk_i = ~clk_i;

  usb_sniffer_axi_burst dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_wr_i(inport_wr_i), .inport_rd_i(inport_rd_i), .inport_len_i(inport_len_i),
    .inport_addr_i(inport_addr_i), .inport_write_data_i(inport_write_data_i),
    .inport_accept_o(inport_accept_o), .inport_ack_o(inport_ack_o),
    .inport_error_o(inport_error_o), .inport_last_o(inport_last_o),
    .inport_read_data_o(inport_read_data_o),
    .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst),
    .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen), .arburst(arburst),
    .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit stall_mode = 0, aw_block = 0, w_block = 0, r_hold = 0;
  int r_err_beat = -1;

  int aw_cnt, wb_cnt, b_sent, r_beat;
  logic [31:0] r_addr_q[$];
  logic [7:0]  r_len_q[$];

  logic [40:0] ev_q[$], exp_ev[$];
  logic [36:0] w_q[$], exp_w[$];
  logic [33:0] ack_q[$];
  int exp_acks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_pat(input logic [31:0] a, input int beat);
    return {a[31:8] ^ 24'hC0FFEE, 8'(beat)};
  endfunction

  function automatic bit rnd();
    return ($urandom_range(0, 9) < 6);
  endfunction

  // AXI slave: drives readies/responses at negedge, records what will handshake at the next posedge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      aw_cnt = 0; wb_cnt = 0; b_sent = 0; r_beat = 0;
      r_addr_q.delete(); r_len_q.delete();
    end else begin
      if (inport_ack_o) ack_q.push_back({inport_error_o, inport_last_o, inport_read_data_o});
      awready = !aw_block && (!stall_mode || rnd());
      wready  = !w_block && (!stall_mode || rnd());
      arready = !stall_mode || rnd();
      bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      if (b_sent < aw_cnt && b_sent < wb_cnt && (!stall_mode || rnd())) begin
        bvalid = 1;
        b_sent++;
      end else if (!r_hold && r_len_q.size() > 0 && (!stall_mode || rnd())) begin
        rvalid = 1;
        rdata  = rd_pat(r_addr_q[0], r_beat);
        rresp  = (r_beat == r_err_beat) ? 2'b10 : 2'b00;
        rlast  = (r_beat == int'(r_len_q[0]));
        if (rlast) begin
          void'(r_addr_q.pop_front());
          void'(r_len_q.pop_front());
          r_beat = 0;
        end else begin
          r_beat++;
        end
      end
      if (awvalid && awready) begin
        ev_q.push_back({1'b0, awlen, awaddr});
        aw_cnt++;
        check("aw_burst_id", 64'({awburst, awid}), 64'({2'b01, 4'h0}));
      end
      if (arvalid && arready) begin
        ev_q.push_back({1'b1, arlen, araddr});
        r_addr_q.push_back(araddr);
        r_len_q.push_back(arlen);
        check("ar_burst_id", 64'({arburst, arid}), 64'({2'b01, 4'h0}));
      end
      if (wvalid && wready) begin
        w_q.push_back({wlast, wstrb, wdata});
        if (wlast) wb_cnt++;
      end
    end
  end

  task automatic put_beat(input logic rd, input logic [3:0] strb, input logic [7:0] len,
                          input logic [31:0] addr, input logic [31:0] data);
    int t = 0;
    @(negedge clk_i);
    inport_rd_i = rd; inport_wr_i = strb; inport_len_i = len;
    inport_addr_i = addr; inport_write_data_i = data;
    #1;
    while (!inport_accept_o && t < 400) begin
      @(negedge clk_i); #1; t++;
    end
    check("accept_wait", 64'(t < 400), 64'd1);
    @(posedge clk_i); #1;
    inport_rd_i = 0; inport_wr_i = 0;
  endtask

  task automatic send_write(input logic [7:0] len, input logic [31:0] addr,
                            input logic [3:0] strb_fix, input logic [31:0] d0);
    logic [31:0] d;
    logic [3:0] s;
    exp_ev.push_back({1'b0, len, addr & 32'hFFFF_FFFC});
    exp_acks++;
    for (int i = 0; i <= int'(len); i++) begin
      d = (i == 0 && d0 != 0) ? d0 : $urandom;
      s = (strb_fix != 0) ? strb_fix : 4'($urandom_range(1, 15));
      put_beat(1'b0, s, len, addr, d);
      exp_w.push_back({(i == int'(len)), s, d});
    end
  endtask

  task automatic send_read(input logic [7:0] len, input logic [31:0] addr);
    exp_ev.push_back({1'b1, len, addr & 32'hFFFF_FFFC});
    exp_acks += int'(len) + 1;
    put_beat(1'b1, 4'h0, len, addr, $urandom);
  endtask

  task automatic wait_acks();
    int t = 0;
    while (ack_q.size() < exp_acks && t < 3000) begin
      @(negedge clk_i); #1; t++;
    end
    check("ack_count", 64'(ack_q.size()), 64'(exp_acks));
  endtask

  task automatic compare_streams(input string tag);
    int nl = 0;
    check({tag, "_ev_n"}, 64'(ev_q.size()), 64'(exp_ev.size()));
    for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), 64'(ev_q[i]), 64'(exp_ev[i]));
    check({tag, "_w_n"}, 64'(w_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < w_q.size() && i < exp_w.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(w_q[i]), 64'(exp_w[i]));
    foreach (ack_q[i]) if (ack_q[i][32]) nl++;
    check({tag, "_last_n"}, 64'(nl), 64'(exp_ev.size()));
    ev_q.delete(); exp_ev.delete(); w_q.delete(); exp_w.delete(); ack_q.delete();
    exp_acks = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, 64'({awvalid, wvalid, arvalid}), 64'd0);
    check({tag, "_accept"}, 64'(inport_accept_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [7:0] l;
    rst_i = 1;
    inport_wr_i = 0; inport_rd_i = 0; inport_len_i = 0;
    inport_addr_i = 0; inport_write_data_i = 0;
    repeat (3) @(negedge clk_i);
    #1;
    check_idle_outputs("reset");
    check("reset_bready_rready", 64'({bready, rready}), 64'd3);
    check("reset_ack", 64'({inport_ack_o, inport_last_o}), 64'd0);
    @(negedge clk_i); rst_i = 0;
    #1;
    check_idle_outputs("post_reset");

    // single aligned-down write, one-cycle command latency
    send_write(8'd0, 32'h1003, 4'hF, 32'hA5A5A5A5);
    @(negedge clk_i); #1;
    check("aw_latency", 64'(awvalid), 64'd1);
    check("aw_addr_align", 64'({awaddr, awlen}), 64'({32'h1000, 8'd0}));
    wait_acks();
    check("single_ack", 64'(ack_q[0][33:32]), 64'b01);
    compare_streams("single");

    // AW held off while data flows ahead
    aw_block = 1;
    send_write(8'd3, 32'h1100, 4'hF, 32'h0);
    repeat (5) @(negedge clk_i);
    #1;
    check("awhold_aw_pending", 64'({awvalid, 8'(ev_q.size())}), 64'({1'b1, 8'd0}));
    check("awhold_w_ahead", 64'(w_q.size()), 64'd4);
    aw_block = 0;
    wait_acks();
    compare_streams("awhold");

    // read burst with an error on beat 3
    r_err_beat = 3;
    send_read(8'd7, 32'h2000);
    wait_acks();
    for (int i = 0; i < 8 && i < ack_q.size(); i++)
      check($sformatf("rd_ack%0d", i), 64'(ack_q[i]),
            64'({(i == 3), (i == 7), rd_pat(32'h2000, i)}));
    compare_streams("read");
    r_err_beat = -1;

    // outstanding limit
    r_hold = 1;
    for (int i = 0; i < 16; i++) send_read(8'd0, 32'h3000 + 32'(i * 4));
    @(negedge clk_i); #1;
    check("outstanding_full", 64'(inport_accept_o), 64'd0);
    r_hold = 0;
    t = 0;
    while (ack_q.size() == 0 && t < 100) begin
      @(negedge clk_i); #1; t++;
    end
    check("outstanding_release", 64'(inport_accept_o), 64'd1);
    wait_acks();
    compare_streams("limit");

    // stalled channels: W,R,W then a random mix
    stall_mode = 1;
    send_write(8'($urandom_range(0, 3)), $urandom, 4'h0, 32'h0);
    send_read(8'($urandom_range(0, 3)), $urandom);
    send_write(8'($urandom_range(0, 3)), $urandom, 4'h0, 32'h0);
    for (int i = 0; i < 24; i++) begin
      l = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) send_read(l, $urandom);
      else send_write(l, $urandom, 4'h0, 32'h0);
    end
    wait_acks();
    compare_streams("random");
    stall_mode = 0;

    // reset in the middle of a write burst
    aw_block = 1; w_block = 1;
    put_beat(1'b0, 4'hF, 8'd3, 32'h5000, 32'h11111111);
    put_beat(1'b0, 4'hF, 8'd3, 32'h5000, 32'h22222222);
    @(negedge clk_i); rst_i = 1;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    #1;
    check_idle_outputs("release");
    @(negedge clk_i); #1;
    check_idle_outputs("release_next");
    ev_q.delete(); w_q.delete(); ack_q.delete();
    aw_block = 0; w_block = 0;
    send_write(8'd1, 32'h4000, 4'h0, 32'h0);
    wait_acks();
    compare_streams("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
